// File: rtl/rvi_decode_stage_pkg.sv
// RV32I decode types: opcode/format/funct enums, decoded instruction record and the
// combinational decode function shared by the decode stage.
package rvi_pkg;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} inst_fmt_e;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_e;

  // funct encodings are {funct7, funct3}
  typedef enum logic [9:0] {
    BR_BEQ = 10'h000, BR_BNE = 10'h001, BR_BLT = 10'h004,
    BR_BGE = 10'h005, BR_BLTU = 10'h006, BR_BGEU = 10'h007
  } branch_funct_e;

  typedef enum logic [9:0] {
    LD_LB = 10'h000, LD_LH = 10'h001, LD_LW = 10'h002, LD_LBU = 10'h004, LD_LHU = 10'h005
  } load_funct_e;

  typedef enum logic [9:0] {ST_SB = 10'h000, ST_SH = 10'h001, ST_SW = 10'h002} store_funct_e;

  typedef enum logic [9:0] {
    OI_ADDI = 10'h000, OI_SLLI = 10'h001, OI_SLTI = 10'h002, OI_SLTIU = 10'h003,
    OI_XORI = 10'h004, OI_SRLI = 10'h005, OI_SRAI = 10'h105, OI_ORI = 10'h006,
    OI_ANDI = 10'h007
  } op_imm_funct_e;

  typedef enum logic [9:0] {
    OP_ADD = 10'h000, OP_SUB = 10'h100, OP_SLL = 10'h001, OP_SLT = 10'h002,
    OP_SLTU = 10'h003, OP_XOR = 10'h004, OP_SRL = 10'h005, OP_SRA = 10'h105,
    OP_OR = 10'h006, OP_AND = 10'h007
  } op_funct_e;

  typedef enum logic [9:0] {MM_FENCE = 10'h000} misc_mem_funct_e;

  typedef enum logic [9:0] {
    SYS_PRIV = 10'h000, SYS_CSRRW = 10'h001, SYS_CSRRS = 10'h002, SYS_CSRRC = 10'h003,
    SYS_CSRRWI = 10'h005, SYS_CSRRSI = 10'h006, SYS_CSRRCI = 10'h007
  } system_funct_e;

  typedef struct packed {
    opcode_e     opcode;
    inst_fmt_e   fmt;
    logic [9:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_en;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  function automatic logic funct_ok(input logic [6:0] op, input logic [9:0] f);
    logic ok;
    ok = 1'b1;
    case (op)
      OPC_JALR:     ok = (f == 10'h000);
      OPC_BRANCH:   case (f) BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: ok = 1'b1;
                      default: ok = 1'b0; endcase
      OPC_LOAD:     case (f) LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
                      default: ok = 1'b0; endcase
      OPC_STORE:    case (f) ST_SB, ST_SH, ST_SW: ok = 1'b1; default: ok = 1'b0; endcase
      OPC_OP_IMM:   case (f) OI_ADDI, OI_SLLI, OI_SLTI, OI_SLTIU, OI_XORI, OI_SRLI, OI_SRAI,
                      OI_ORI, OI_ANDI: ok = 1'b1; default: ok = 1'b0; endcase
      OPC_OP:       case (f) OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                      OP_OR, OP_AND: ok = 1'b1; default: ok = 1'b0; endcase
      OPC_MISC_MEM: ok = (f == MM_FENCE);
      OPC_SYSTEM:   case (f) SYS_PRIV, SYS_CSRRW, SYS_CSRRS, SYS_CSRRC, SYS_CSRRWI, SYS_CSRRSI,
                      SYS_CSRRCI: ok = 1'b1; default: ok = 1'b0; endcase
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic decoded_t decode(input logic [31:0] inst, input logic funct_chk = 1'b1);
    decoded_t   d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [9:0] funct;
    logic       legal;
    logic       use_rd, use_rs1, use_rs2;
    logic [31:0] imm;
    inst_fmt_e  fmt;

    d     = '0;
    op    = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    legal = (inst[1:0] == 2'b11);
    fmt   = FMT_R;
    case (op)
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_STORE:          fmt = FMT_S;
      OPC_OP:             fmt = FMT_R;
      default:            legal = 1'b0;
    endcase

    // funct7 only carries meaning for OP and the OP_IMM shifts; elsewhere it is immediate bits
    if (fmt == FMT_U || fmt == FMT_J)
      funct = '0;
    else if (op == OPC_OP || (op == OPC_OP_IMM && f3[1:0] == 2'b01))
      funct = {f7, f3};
    else
      funct = {7'b0, f3};

    if (funct_chk && !funct_ok(op, funct))
      legal = 1'b0;

    use_rd  = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J);
    use_rs1 = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B);
    use_rs2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);

    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase

    d.opcode = opcode_e'(op);
    d.fmt    = fmt;
    d.funct  = funct;
    if (legal) begin
      d.rd     = use_rd  ? inst[11:7]  : 5'd0;
      d.rs1    = use_rs1 ? inst[19:15] : 5'd0;
      d.rs2    = use_rs2 ? inst[24:20] : 5'd0;
      d.rd_en  = use_rd && (inst[11:7] != 5'd0);
      d.rs1_en = use_rs1;
      d.rs2_en = use_rs2;
      d.imm    = imm;
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/rvi_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rvi_decode_stage_if #(parameter int unsigned PC_WIDTH = 32);
  import rvi_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  opcode_e             out_opcode;
  inst_fmt_e           out_fmt;
  logic [9:0]          out_funct;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic                out_rd_en;
  logic                out_rs1_en;
  logic                out_rs2_en;
  logic [31:0]         out_imm;
  logic                out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_fmt, out_funct, out_rd, out_rs1,
           out_rs2, out_rd_en, out_rs1_en, out_rs2_en, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_fmt, out_funct, out_rd, out_rs1,
           out_rs2, out_rd_en, out_rs1_en, out_rs2_en, out_imm, out_illegal
  );
endinterface

// File: rtl/rvi_decode_stage_skid.sv
// Generic 2-entry valid/ready register slice with flush; both in_ready and out_valid
// come straight from flops.
module rvi_skid_buffer
  import rvi_pkg::*;
#(
  parameter type T = decoded_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state, state_nx;
  T            main_q, skid_q;
  logic        ready_q, valid_q;
  logic        accept, pop;
  logic        load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid && ready_q;
  assign pop       = valid_q && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: if (accept) begin
          state_nx     = SKID_ONE;
          load_main_in = 1'b1;
        end
        SKID_ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nx  = SKID_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nx = SKID_EMPTY;
          end
        end
        SKID_FULL: if (pop) begin
          state_nx       = SKID_ONE;
          load_main_skid = 1'b1;
        end
        default: state_nx = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SKID_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != SKID_FULL);
      valid_q <= (state_nx != SKID_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/rvi_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, packed with its PC
// into a registered 2-entry slice towards execute.
module rvi_decode_stage
  import rvi_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter bit          FUNCT_CHK = 1'b1
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  rvi_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    decoded_t            dec;
  } entry_t;

  entry_t in_entry, out_entry;

  always_comb begin
    in_entry.pc  = bus.in_pc;
    in_entry.dec = decode(bus.in_inst, FUNCT_CHK);
  end

  rvi_skid_buffer #(.T(entry_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign bus.out_pc      = out_entry.pc;
  assign bus.out_opcode  = out_entry.dec.opcode;
  assign bus.out_fmt     = out_entry.dec.fmt;
  assign bus.out_funct   = out_entry.dec.funct;
  assign bus.out_rd      = out_entry.dec.rd;
  assign bus.out_rs1     = out_entry.dec.rs1;
  assign bus.out_rs2     = out_entry.dec.rs2;
  assign bus.out_rd_en   = out_entry.dec.rd_en;
  assign bus.out_rs1_en  = out_entry.dec.rs1_en;
  assign bus.out_rs2_en  = out_entry.dec.rs2_en;
  assign bus.out_imm     = out_entry.dec.imm;
  assign bus.out_illegal = out_entry.dec.illegal;

endmodule

// File: tb/tb_rvi_decode_stage.sv
// Directed bench for rvi_decode_stage: decode vectors, skid back-pressure, flush, async reset.
module tb_rvi_decode_stage;
  import rvi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  rvi_decode_stage_if #(.PC_WIDTH(32)) bus();

  rvi_decode_stage #(.PC_WIDTH(32), .FUNCT_CHK(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addi_of(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  // Offers one instruction with out_ready high, returns on the negedge after acceptance.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    int n;
    n = 0;
    @(negedge clk);
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b required 1 for pc %h", bus.in_ready, pc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if ({bus.out_pc, bus.out_imm, bus.out_funct, bus.out_illegal} !== '0) begin
      errors++; $display("FAIL reset_data: pc=%h imm=%h funct=%h ill=%b required all 0",
                         bus.out_pc, bus.out_imm, bus.out_funct, bus.out_illegal);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi;
    issue(32'h00500093, 32'h1000);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL addi_latency: out_valid=%b required 1", bus.out_valid);
    end
    checks++;
    if (bus.out_opcode !== OPC_OP_IMM || bus.out_fmt !== FMT_I || bus.out_funct !== 10'h000) begin
      errors++; $display("FAIL addi_class: op=%b fmt=%0d funct=%h required 0010011/1/000",
                         bus.out_opcode, bus.out_fmt, bus.out_funct);
    end
    checks++;
    if ({bus.out_rd, bus.out_rs1, bus.out_rs2} !== {5'd1, 5'd0, 5'd0}) begin
      errors++; $display("FAIL addi_regs: rd=%0d rs1=%0d rs2=%0d required 1/0/0",
                         bus.out_rd, bus.out_rs1, bus.out_rs2);
    end
    checks++;
    if ({bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en, bus.out_illegal} !== 4'b1100 ||
        bus.out_imm !== 32'd5 || bus.out_pc !== 32'h1000) begin
      errors++; $display("FAIL addi_fields: en/ill=%b%b%b%b imm=%h pc=%h required 1100/5/1000",
                         bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en, bus.out_illegal,
                         bus.out_imm, bus.out_pc);
    end
  endtask

  task automatic test_sub;
    issue(32'h402081B3, 32'h1004);
    checks++;
    if (bus.out_fmt !== FMT_R || bus.out_funct !== 10'b0100000000 || bus.out_imm !== 32'd0) begin
      errors++; $display("FAIL sub_class: fmt=%0d funct=%b imm=%h required 0/0100000000/0",
                         bus.out_fmt, bus.out_funct, bus.out_imm);
    end
    checks++;
    if ({bus.out_rd, bus.out_rs1, bus.out_rs2} !== {5'd3, 5'd1, 5'd2} ||
        {bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en, bus.out_illegal} !== 4'b1110) begin
      errors++; $display("FAIL sub_regs: rd=%0d rs1=%0d rs2=%0d en/ill=%b%b%b%b required 3/1/2 1110",
                         bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_rd_en, bus.out_rs1_en,
                         bus.out_rs2_en, bus.out_illegal);
    end
  endtask

  task automatic test_branch_lui;
    issue(32'hFE000EE3, 32'h1008);
    checks++;
    if (bus.out_fmt !== FMT_B || bus.out_imm !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL beq_imm: fmt=%0d imm=%h required 3/fffffffc", bus.out_fmt, bus.out_imm);
    end
    checks++;
    if ({bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en, bus.out_illegal} !== 4'b0110 ||
        bus.out_rd !== 5'd0) begin
      errors++; $display("FAIL beq_en: en/ill=%b%b%b%b rd=%0d required 0110/0", bus.out_rd_en,
                         bus.out_rs1_en, bus.out_rs2_en, bus.out_illegal, bus.out_rd);
    end
    issue(32'h123452B7, 32'h100C);
    checks++;
    if (bus.out_fmt !== FMT_U || bus.out_imm !== 32'h12345000 || bus.out_rd !== 5'd5 ||
        {bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en} !== 3'b100) begin
      errors++; $display("FAIL lui: fmt=%0d imm=%h rd=%0d en=%b%b%b required 4/12345000/5/100",
                         bus.out_fmt, bus.out_imm, bus.out_rd, bus.out_rd_en, bus.out_rs1_en,
                         bus.out_rs2_en);
    end
  endtask

  task automatic test_illegal;
    issue(32'h00000000, 32'h2000);
    checks++;
    if (bus.out_illegal !== 1'b1 || {bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en} !== 3'b000 ||
        bus.out_imm !== 32'd0 || bus.out_pc !== 32'h2000) begin
      errors++; $display("FAIL ill_zero: ill=%b en=%b%b%b imm=%h pc=%h required 1/000/0/2000",
                         bus.out_illegal, bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en,
                         bus.out_imm, bus.out_pc);
    end
    issue(32'h00000007, 32'h2004);
    checks++;
    if (bus.out_illegal !== 1'b1 || bus.out_opcode !== 7'b0000111) begin
      errors++; $display("FAIL ill_opcode: ill=%b op=%b required 1/0000111",
                         bus.out_illegal, bus.out_opcode);
    end
    issue(32'h00006003, 32'h2008);
    checks++;
    if (bus.out_illegal !== 1'b1 || bus.out_opcode !== OPC_LOAD || bus.out_rs1_en !== 1'b0) begin
      errors++; $display("FAIL ill_load_f3: ill=%b op=%b rs1_en=%b required 1/0000011/0",
                         bus.out_illegal, bus.out_opcode, bus.out_rs1_en);
    end
    issue(32'h0000A003, 32'h200C);
    checks++;
    if (bus.out_illegal !== 1'b0 || bus.out_funct !== 10'h002 || bus.out_rs1_en !== 1'b1) begin
      errors++; $display("FAIL legal_lw: ill=%b funct=%h rs1_en=%b required 0/002/1",
                         bus.out_illegal, bus.out_funct, bus.out_rs1_en);
    end
  endtask

  task automatic test_back_to_back;
    int sent, recv, last_pop;
    sent = 0; recv = 0; last_pop = -1;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 3);
      bus.in_valid  = (sent < 8);
      bus.in_inst   = addi_of(sent + 1);
      bus.in_pc     = 32'h100 + 32'(4 * sent);
      if (cyc == 2) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_full: in_ready=%b out_valid=%b required 0/1",
                             bus.in_ready, bus.out_valid);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if ({bus.out_pc, bus.out_imm} !== {32'h100 + 32'(4 * recv), 32'(recv + 1)}) begin
          errors++; $display("FAIL b2b_order[%0d]: pc=%h imm=%h required %h/%h", recv, bus.out_pc,
                             bus.out_imm, 32'h100 + 32'(4 * recv), 32'(recv + 1));
        end
        recv++;
        last_pop = cyc;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (recv != 8 || last_pop != 10) begin
      errors++; $display("FAIL b2b_throughput: recv=%0d last_pop_cycle=%0d required 8/10",
                         recv, last_pop);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid=%b required 0 (duplicate)", bus.out_valid);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = addi_of(21);
    bus.in_pc     = 32'h200;
    @(negedge clk);
    bus.in_inst   = addi_of(22);
    bus.in_pc     = 32'h204;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_pre_full: in_ready=%b required 0", bus.in_ready);
    end
    flush         = 1'b1;
    bus.in_inst   = addi_of(23);
    bus.in_pc     = 32'h208;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: out_valid=%b in_ready=%b required 0/1",
                         bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: out_valid=%b required 0", bus.out_valid);
    end
    issue(addi_of(24), 32'h20C);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20C || bus.out_imm !== 32'd24) begin
      errors++; $display("FAIL flush_resume: valid=%b pc=%h imm=%h required 1/20c/18",
                         bus.out_valid, bus.out_pc, bus.out_imm);
    end
  endtask

  task automatic test_async_reset;
    issue(addi_of(7), 32'h300);
    bus.in_valid = 1'b1;
    bus.in_inst  = addi_of(8);
    bus.in_pc    = 32'h304;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.out_pc, bus.out_imm, bus.out_rd_en} !== '0) begin
      errors++; $display("FAIL async_reset: valid=%b ready=%b pc=%h imm=%h rd_en=%b required 0/1/0/0/0",
                         bus.out_valid, bus.in_ready, bus.out_pc, bus.out_imm, bus.out_rd_en);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_hold: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_branch_lui();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
